source_msg_packer: RTL and testbench

Per-source message packer on the FPGA-to-host path. It collects bytes from one data source (UART/serial receiver), packs them into 16-bit words and groups them into messages delimited by an idle gap. Each closed message is offered to the slave-FIFO write arbiter through the GOT_FULL_MSG / MSG_LEN / PARITY / Q / RD_REQ / MSG_START handshake. One instance per source; the buses are concatenated `NUM_SOURCES` wide at the top level.

---
 rtl/source_msg_packer_pkg.sv | 13 +
 rtl/source_msg_packer_fifo.sv | 52 +++++
 rtl/source_msg_packer.sv | 191 +++++++++++++++++++
 tb/tb_source_msg_packer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/source_msg_packer_pkg.sv
// Shared constants and types for the per-source message packer.
package source_msg_packer_pkg;

  localparam int unsigned DEFAULT_MSG_TIMEOUT = 8;
  localparam int unsigned NUM_SOURCES         = 4;
  localparam int unsigned MAX_MSG_WORDS       = 255;

  typedef struct packed {
    logic [7:0] len;
    logic       parity;
  } desc_t;

endpackage

// File: rtl/source_msg_packer_fifo.sv
// Show-ahead word FIFO with a speculative write pointer that is either
// committed (made visible to the reader) or rolled back to the last commit.
module msg_word_fifo #(
  parameter int unsigned ADDR_W = 9
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        wr_en_i,
  input  logic [15:0] wr_data_i,
  input  logic        commit_i,
  input  logic        rollback_i,
  input  logic        rd_en_i,
  output logic [15:0] rd_data_o,
  output logic        full_o,
  output logic        empty_o
);

  logic [15:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] spec_q, spec_d;
  logic [ADDR_W-1:0] cmt_q, cmt_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [ADDR_W-1:0] spec_inc;

  always_comb begin
    spec_inc = spec_q + {{(ADDR_W-1){1'b0}}, wr_en_i};
    spec_d   = rollback_i ? cmt_q : spec_inc;
    cmt_d    = commit_i ? spec_inc : cmt_q;
    rd_d     = rd_q + {{(ADDR_W-1){1'b0}}, rd_en_i};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      spec_q <= '0;
      cmt_q  <= '0;
      rd_q   <= '0;
    end else begin
      spec_q <= spec_d;
      cmt_q  <= cmt_d;
      rd_q   <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[spec_q] <= wr_data_i;
  end

  // One slot stays empty so full and empty are distinguishable.
  assign full_o    = (spec_q + {{(ADDR_W-1){1'b0}}, 1'b1}) == rd_q;
  assign empty_o   = (cmt_q == rd_q);
  assign rd_data_o = empty_o ? '0 : mem[rd_q];

endmodule

// File: rtl/source_msg_packer.sv
// Packs source bytes into 16-bit words, groups them into idle-delimited
// messages and presents committed messages to the slave-FIFO write arbiter.
module source_msg_packer
  import source_msg_packer_pkg::*;
#(
  parameter int unsigned DATA_DEPTH_LOG2 = 9,
  parameter int unsigned DESC_DEPTH_LOG2 = 2,
  parameter int unsigned MSG_TIMEOUT     = DEFAULT_MSG_TIMEOUT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  BYTE_IN,
  input  logic        BYTE_VALID,
  input  logic        RD_REQ,
  input  logic        MSG_START,
  output logic [15:0] Q,
  output logic        GOT_FULL_MSG,
  output logic [7:0]  MSG_LEN,
  output logic        PARITY,
  output logic        OVERFLOW,
  output logic        SEQ_ERR
);

  typedef enum logic [1:0] {IDLE, COLLECT, DROP} state_e;

  localparam int unsigned GAP_W = $clog2(MSG_TIMEOUT + 1);
  localparam int unsigned DESC_DEPTH = 2**DESC_DEPTH_LOG2;
  localparam logic [DESC_DEPTH_LOG2:0] DESC_FULL_CNT = (DESC_DEPTH_LOG2+1)'(DESC_DEPTH);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MSG_TIMEOUT - 1);
  localparam logic [7:0] LAST_WORD_IDX = 8'(MAX_MSG_WORDS - 1);

  state_e                     state_q, state_d;
  logic [7:0]                 lo_q, lo_d;
  logic                       have_lo_q, have_lo_d;
  logic [7:0]                 wcnt_q, wcnt_d;
  logic [GAP_W-1:0]           gap_q, gap_d;
  logic [7:0]                 rdcnt_q, rdcnt_d;
  logic                       seq_err_q, ovf_q;
  desc_t                      desc_mem [DESC_DEPTH];
  logic [DESC_DEPTH_LOG2-1:0] desc_wp_q, desc_rp_q;
  logic [DESC_DEPTH_LOG2:0]   desc_cnt_q, desc_cnt_d;

  logic        fifo_full, fifo_empty;
  logic [15:0] fifo_q;
  logic        wr_en, close, close_par, commit, discard;
  logic [15:0] wr_data;
  logic        got_full, rd_fire, desc_pop, desc_full;
  desc_t       head, new_desc;

  assign got_full  = (desc_cnt_q != '0);
  assign head      = desc_mem[desc_rp_q];
  assign rd_fire   = RD_REQ && got_full;
  assign desc_pop  = rd_fire && ((rdcnt_q + 8'd1) == head.len);
  // A pop on the closing edge frees the slot the new descriptor needs.
  assign desc_full = (desc_cnt_q == DESC_FULL_CNT) && !desc_pop;

  msg_word_fifo #(.ADDR_W(DATA_DEPTH_LOG2)) u_word_fifo (
    .clk_i      (CLK),
    .rst_n_i    (RST),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_data),
    .commit_i   (commit),
    .rollback_i (discard),
    .rd_en_i    (rd_fire),
    .rd_data_o  (fifo_q),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      lo_q       <= '0;
      have_lo_q  <= 1'b0;
      wcnt_q     <= '0;
      gap_q      <= '0;
      rdcnt_q    <= '0;
      seq_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
      desc_wp_q  <= '0;
      desc_rp_q  <= '0;
      desc_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      have_lo_q  <= have_lo_d;
      wcnt_q     <= wcnt_d;
      gap_q      <= gap_d;
      rdcnt_q    <= rdcnt_d;
      seq_err_q  <= seq_err_q | (MSG_START && (rdcnt_q != '0));
      ovf_q      <= discard;
      desc_wp_q  <= desc_wp_q + DESC_DEPTH_LOG2'(commit);
      desc_rp_q  <= desc_rp_q + DESC_DEPTH_LOG2'(desc_pop);
      desc_cnt_q <= desc_cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (commit) desc_mem[desc_wp_q] <= new_desc;
  end

  // Write-side control decode (FSM outputs).
  always_comb begin
    wr_en     = 1'b0;
    wr_data   = '0;
    close     = 1'b0;
    close_par = 1'b0;
    commit    = 1'b0;
    discard   = 1'b0;
    if (state_q == COLLECT) begin
      if (BYTE_VALID && have_lo_q) begin
        if (fifo_full) discard = 1'b1;
        else begin
          wr_en   = 1'b1;
          wr_data = {BYTE_IN, lo_q};
          close   = (wcnt_q == LAST_WORD_IDX);
        end
      end else if (!BYTE_VALID && (gap_q == GAP_LAST)) begin
        if (have_lo_q && fifo_full) discard = 1'b1;
        else begin
          wr_en     = have_lo_q;
          wr_data   = {8'h00, lo_q};
          close     = 1'b1;
          close_par = have_lo_q;
        end
      end
      if (close) begin
        if (desc_full) discard = 1'b1;
        else           commit  = 1'b1;
      end
    end
    new_desc.len    = wcnt_q + {7'd0, wr_en};
    new_desc.parity = close_par;
  end

  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    have_lo_d = have_lo_q;
    wcnt_d    = wcnt_q + {7'd0, wr_en};
    gap_d     = gap_q;
    case (state_q)
      IDLE: begin
        if (BYTE_VALID) begin
          state_d   = COLLECT;
          lo_d      = BYTE_IN;
          have_lo_d = 1'b1;
          wcnt_d    = '0;
          gap_d     = '0;
        end
      end
      COLLECT: begin
        gap_d = BYTE_VALID ? '0 : gap_q + GAP_W'(1);
        if (BYTE_VALID && !have_lo_q) begin
          lo_d      = BYTE_IN;
          have_lo_d = 1'b1;
        end else if (BYTE_VALID) begin
          have_lo_d = 1'b0;
        end
        if (discard) begin
          state_d = DROP;
          gap_d   = '0;
        end else if (close) begin
          state_d = IDLE;
        end
      end
      DROP: begin
        gap_d = BYTE_VALID ? '0 : gap_q + GAP_W'(1);
        if (!BYTE_VALID && (gap_q == GAP_LAST)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdcnt_d = rdcnt_q;
    if (desc_pop)     rdcnt_d = '0;
    else if (rd_fire) rdcnt_d = rdcnt_q + 8'd1;
    desc_cnt_d = desc_cnt_q;
    if (commit && !desc_pop)      desc_cnt_d = desc_cnt_q + 1'b1;
    else if (!commit && desc_pop) desc_cnt_d = desc_cnt_q - 1'b1;
  end

  assign Q            = fifo_empty ? '0 : fifo_q;
  assign GOT_FULL_MSG = got_full;
  assign MSG_LEN      = got_full ? head.len : '0;
  assign PARITY       = got_full ? head.parity : 1'b0;
  assign OVERFLOW     = ovf_q;
  assign SEQ_ERR      = seq_err_q;

endmodule

// File: tb/tb_source_msg_packer.sv
// Directed self-checking bench for source_msg_packer (MSG_TIMEOUT = 8).
module tb_source_msg_packer;

  localparam int unsigned T = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  BYTE_IN = '0;
  logic        BYTE_VALID = 1'b0;
  logic        RD_REQ = 1'b0;
  logic        MSG_START = 1'b0;
  logic [15:0] Q;
  logic        GOT_FULL_MSG;
  logic [7:0]  MSG_LEN;
  logic        PARITY;
  logic        OVERFLOW;
  logic        SEQ_ERR;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned ovf_cnt;

  source_msg_packer #(
    .DATA_DEPTH_LOG2 (9),
    .DESC_DEPTH_LOG2 (2),
    .MSG_TIMEOUT     (T)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .BYTE_IN      (BYTE_IN),
    .BYTE_VALID   (BYTE_VALID),
    .RD_REQ       (RD_REQ),
    .MSG_START    (MSG_START),
    .Q            (Q),
    .GOT_FULL_MSG (GOT_FULL_MSG),
    .MSG_LEN      (MSG_LEN),
    .PARITY       (PARITY),
    .OVERFLOW     (OVERFLOW),
    .SEQ_ERR      (SEQ_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    BYTE_IN = b;
    BYTE_VALID = 1'b1;
    @(posedge CLK); #1;
    BYTE_VALID = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic rd();
    RD_REQ = 1'b1;
    @(posedge CLK); #1;
    RD_REQ = 1'b0;
  endtask

  task automatic start_pulse();
    MSG_START = 1'b1;
    @(posedge CLK); #1;
    MSG_START = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    check("rst_q", Q, 16'h0000);
    check("rst_got", {15'd0, GOT_FULL_MSG}, 16'd0);
    check("rst_len", {8'd0, MSG_LEN}, 16'd0);
    check("rst_par", {15'd0, PARITY}, 16'd0);
    check("rst_ovf", {15'd0, OVERFLOW}, 16'd0);
    check("rst_seq", {15'd0, SEQ_ERR}, 16'd0);
    RST = 1'b1;
    idle(2);

    // Even message: 11,22,33,44
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    idle(T - 1);
    check("t1_got_early", {15'd0, GOT_FULL_MSG}, 16'd0);
    idle(1);
    check("t1_got", {15'd0, GOT_FULL_MSG}, 16'd1);
    check("t1_len", {8'd0, MSG_LEN}, 16'd2);
    check("t1_par", {15'd0, PARITY}, 16'd0);
    check("t1_q0", Q, 16'h2211);
    RD_REQ = 1'b1;
    @(posedge CLK); #1;
    check("t1_q1", Q, 16'h4433);
    check("t1_got_mid", {15'd0, GOT_FULL_MSG}, 16'd1);
    @(posedge CLK); #1;
    RD_REQ = 1'b0;
    check("t1_got_end", {15'd0, GOT_FULL_MSG}, 16'd0);
    check("t1_len_end", {8'd0, MSG_LEN}, 16'd0);

    // Odd message: AA,BB,CC
    send(8'hAA); send(8'hBB); send(8'hCC);
    idle(T);
    check("t2_len", {8'd0, MSG_LEN}, 16'd2);
    check("t2_par", {15'd0, PARITY}, 16'd1);
    check("t2_q0", Q, 16'hBBAA);
    rd();
    check("t2_q1", Q, 16'h00CC);
    rd();
    check("t2_got_end", {15'd0, GOT_FULL_MSG}, 16'd0);

    // RD_REQ with nothing queued is ignored; byte on the closing edge cancels the close
    rd();
    send(8'h01);
    idle(T - 1);
    send(8'h02);
    check("t3_no_close", {15'd0, GOT_FULL_MSG}, 16'd0);
    idle(T);
    check("t3_len", {8'd0, MSG_LEN}, 16'd1);
    check("t3_par", {15'd0, PARITY}, 16'd0);
    check("t3_q", Q, 16'h0201);
    rd();
    check("t3_got_end", {15'd0, GOT_FULL_MSG}, 16'd0);

    // Two queued messages, MSG_START sequencing
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    idle(T);
    send(8'h05); send(8'h06); send(8'h07); send(8'h08); send(8'h09);
    idle(T);
    check("t4_len_a", {8'd0, MSG_LEN}, 16'd2);
    check("t4_q_a", Q, 16'h0201);
    start_pulse();
    check("t4_seq_clean", {15'd0, SEQ_ERR}, 16'd0);
    rd(); rd();
    check("t4_len_b", {8'd0, MSG_LEN}, 16'd3);
    check("t4_par_b", {15'd0, PARITY}, 16'd1);
    check("t4_q_b", Q, 16'h0605);
    rd();
    start_pulse();
    check("t4_seq_err", {15'd0, SEQ_ERR}, 16'd1);
    check("t4_q_b1", Q, 16'h0807);
    rd();
    check("t4_q_b2", Q, 16'h0009);
    rd();
    check("t4_got_end", {15'd0, GOT_FULL_MSG}, 16'd0);
    check("t4_seq_sticky", {15'd0, SEQ_ERR}, 16'd1);

    // 511 contiguous bytes: 255-word message then a 1-word odd message
    for (int i = 0; i < 511; i++) send(8'(i));
    check("t5_len_a", {8'd0, MSG_LEN}, 16'd255);
    check("t5_par_a", {15'd0, PARITY}, 16'd0);
    check("t5_q_a", Q, 16'h0100);
    idle(T);
    for (int i = 0; i < 100; i++) rd();
    check("t5_q_mid", Q, 16'hC9C8);
    for (int i = 0; i < 155; i++) rd();
    check("t5_len_b", {8'd0, MSG_LEN}, 16'd1);
    check("t5_par_b", {15'd0, PARITY}, 16'd1);
    check("t5_q_b", Q, 16'h00FE);
    rd();
    check("t5_got_end", {15'd0, GOT_FULL_MSG}, 16'd0);

    // 1100 bytes with no reads: third message overflows the word FIFO
    ovf_cnt = 0;
    for (int i = 0; i < 1100; i++) begin
      send(8'(i));
      if (OVERFLOW) ovf_cnt++;
      if (i == 1023) check("t6_ovf_pulse", {15'd0, OVERFLOW}, 16'd1);
      if (i == 1024) check("t6_ovf_one", {15'd0, OVERFLOW}, 16'd0);
    end
    for (int i = 0; i < T + 2; i++) begin
      idle(1);
      if (OVERFLOW) ovf_cnt++;
    end
    check("t6_ovf_cnt", 16'(ovf_cnt), 16'd1);
    check("t6_got", {15'd0, GOT_FULL_MSG}, 16'd1);
    check("t6_len_a", {8'd0, MSG_LEN}, 16'd255);
    check("t6_q_a", Q, 16'h0100);
    for (int i = 0; i < 255; i++) rd();
    check("t6_len_b", {8'd0, MSG_LEN}, 16'd255);
    check("t6_q_b", Q, 16'hFFFE);
    for (int i = 0; i < 255; i++) rd();
    check("t6_got_end", {15'd0, GOT_FULL_MSG}, 16'd0);

    // Asynchronous reset mid-COLLECT with a message queued
    send(8'h10); send(8'h20);
    idle(T);
    check("t7_got_pre", {15'd0, GOT_FULL_MSG}, 16'd1);
    send(8'h30); send(8'h40); send(8'h50);
    #2 RST = 1'b0;
    #1;
    check("t7_rst_q", Q, 16'h0000);
    check("t7_rst_got", {15'd0, GOT_FULL_MSG}, 16'd0);
    check("t7_rst_len", {8'd0, MSG_LEN}, 16'd0);
    check("t7_rst_seq", {15'd0, SEQ_ERR}, 16'd0);
    @(posedge CLK); #3;
    RST = 1'b1;
    idle(2);
    send(8'h5A); send(8'hA5);
    idle(T);
    check("t7_len", {8'd0, MSG_LEN}, 16'd1);
    check("t7_par", {15'd0, PARITY}, 16'd0);
    check("t7_q", Q, 16'hA55A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
